// File: rtl/alu_pkg.sv
// Opcode and FSM encodings shared by the ALU command driver and its users.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_MOV = 3'b110;
  localparam logic [2:0] ALU_INC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // A one-cycle latency still needs a one-bit counter to exist.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/alu_wait_counter.sv
// Loadable down-counter with a zero flag; counts the ALU's registered latency.
module alu_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_cmd_driver.sv
// Issues one ALU command per handshake, waits out the ALU latency, returns the result.
// state | meaning: IDLE accept cmd | ISSUE alu_en pulse | WAIT latency count | RESP hold rsp
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int N   = 16,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_mov,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_o,
  output logic         rsp_z,
  output logic         rsp_n,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_en,
  output logic         alu_mov_sel,
  input  logic [N-1:0] alu_sum,
  input  logic         alu_o,
  input  logic         alu_z,
  input  logic         alu_n,
  output logic [15:0]  ops_done
);

  localparam int            CW       = cnt_width(LAT);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LAT - 1);

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_check
    $error("alu_cmd_driver: LAT must be in 1..4");
  end

  state_t state_q, state_d;
  logic   accept, capture, rsp_hs, cnt_load, cnt_zero;
  logic   cmd_ready_q;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_hs   = 1'b0;
    cnt_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready is a flop so it stays low through reset and the first IDLE cycle after a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_q <= 1'b0;
    end else begin
      cmd_ready_q <= (state_q == ST_IDLE) && !accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_mov_sel <= 1'b0;
    end else if (accept) begin
      alu_a       <= cmd_a;
      alu_b       <= cmd_b;
      alu_op      <= cmd_op;
      alu_mov_sel <= cmd_mov;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_o      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_n      <= 1'b0;
    end else if (capture) begin
      rsp_result <= alu_sum;
      rsp_o      <= alu_o;
      rsp_z      <= alu_z;
      rsp_n      <= alu_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (rsp_hs) begin
      ops_done <= ops_done + 16'd1;
    end
  end

  alu_wait_counter #(
    .W (CW)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  assign cmd_ready = cmd_ready_q;
  assign alu_en    = (state_q == ST_ISSUE);
  assign rsp_valid = (state_q == ST_RESP);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver at LAT=1 and LAT=3, each lane driving a registered ALU model.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        mov;
    int          hold;
    logic [15:0] res;
    logic        o;
    logic        z;
    logic        n;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural 16-bit ALU: {sum, o, z, n}.
  function automatic logic [18:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic mov);
    logic [15:0] s;
    logic        o;
    o = 1'b0;
    case (op)
      ALU_ADD: begin s = a + b; o = (a[15] == b[15]) && (s[15] != a[15]); end
      ALU_SUB: begin s = a - b; o = (a[15] != b[15]) && (s[15] != a[15]); end
      ALU_AND: s = a & b;
      ALU_OR:  s = a | b;
      ALU_XOR: s = a ^ b;
      ALU_NOT: s = ~a;
      ALU_MOV: s = mov ? b : a;
      default: s = a + 16'd1;
    endcase
    return {s, o, (s == 16'd0), s[15]};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int L = (gi == 0) ? 1 : 3;

    logic        rst, cmd_valid, cmd_ready, cmd_mov, rsp_valid, rsp_ready;
    logic        rsp_o, rsp_z, rsp_n, alu_en, alu_mov_sel, alu_o, alu_z, alu_n;
    logic [2:0]  cmd_op, alu_op;
    logic [15:0] cmd_a, cmd_b, rsp_result, alu_a, alu_b, alu_sum, ops_done;
    logic [18:0] pipe [L];
    bit          fin = 1'b0;
    int          cyc = 0, acc_cnt = 0, acc_last = 0, acc_prev = 0;
    logic [18:0] rq [$];
    vec_t        tbl [7];

    alu_cmd_driver #(.N(16), .LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mov(cmd_mov),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_o(rsp_o), .rsp_z(rsp_z), .rsp_n(rsp_n),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
      .alu_mov_sel(alu_mov_sel), .alu_sum(alu_sum),
      .alu_o(alu_o), .alu_z(alu_z), .alu_n(alu_n),
      .ops_done(ops_done)
    );

    // Result is valid for exactly one cycle, L edges after the enabled edge.
    always @(posedge clk) begin
      pipe[0] <= alu_en ? alu_f(alu_op, alu_a, alu_b, alu_mov_sel) : {16'hDEAD, 3'b111};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign {alu_sum, alu_o, alu_z, alu_n} = pipe[L-1];

    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) begin
        acc_prev <= acc_last;
        acc_last <= cyc;
        acc_cnt  <= acc_cnt + 1;
      end
      if (rsp_valid && rsp_ready) rq.push_back({rsp_result, rsp_o, rsp_z, rsp_n});
    end

    task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (cmd_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
    endtask

    task automatic run_cmd(input vec_t v, input logic [15:0] exp_ops, input string tag);
      bit ok;
      bit unstable;
      int seen, en_cnt;
      @(negedge clk);
      cmd_op = v.op; cmd_a = v.a; cmd_b = v.b; cmd_mov = v.mov;
      cmd_valid = 1'b1; rsp_ready = 1'b0;
      wait_ready(ok);
      chk($sformatf("%s ready", tag), ok, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      seen = 0; en_cnt = 0;
      // k = index of the edge E0+k at which the consumer sees rsp_valid
      for (int k = 1; k <= 12; k++) begin
        if (alu_en) en_cnt++;
        if (rsp_valid) begin
          seen = k;
          break;
        end
        @(negedge clk);
      end
      chk($sformatf("%s latency", tag), seen, L + 2);
      chk($sformatf("%s en_pulse", tag), en_cnt, 1);
      chk($sformatf("%s result", tag), {rsp_result, rsp_o, rsp_z, rsp_n}, {v.res, v.o, v.z, v.n});
      chk($sformatf("%s alu_pins", tag), {alu_a, alu_b, alu_op, alu_mov_sel}, {v.a, v.b, v.op, v.mov});
      unstable = 1'b0;
      for (int h = 0; h < v.hold; h++) begin
        if (h == 1) begin
          cmd_valid = 1'b1;
          cmd_a     = ~v.a;
        end
        @(negedge clk);
        if (rsp_valid !== 1'b1 || {rsp_result, rsp_o, rsp_z, rsp_n} !== {v.res, v.o, v.z, v.n}
            || cmd_ready !== 1'b0 || alu_a !== v.a || alu_en !== 1'b0)
          unstable = 1'b1;
      end
      cmd_valid = 1'b0;
      chk($sformatf("%s hold_stable", tag), unstable, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("%s rsp_drop", tag), {rsp_valid, cmd_ready}, 2'b00);
      chk($sformatf("%s ops_done", tag), ops_done, exp_ops);
    endtask

    initial begin
      bit   ok;
      bit   saw;
      int   base;
      vec_t v;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      cmd_mov = 1'b0; rsp_ready = 1'b0;

      tbl[0] = '{ALU_ADD, 16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b1, 1'b0, 1'b1};
      tbl[1] = '{ALU_SUB, 16'h004E, 16'h004E, 1'b0, 5, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{ALU_AND, 16'hFF0F, 16'h0FF0, 1'b0, 1, 16'h0F00, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{ALU_SUB, 16'h8000, 16'h0001, 1'b0, 0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{ALU_XOR, 16'hA5A5, 16'hFFFF, 1'b0, 2, 16'h5A5A, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{ALU_MOV, 16'h1234, 16'hABCD, 1'b1, 0, 16'hABCD, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{ALU_ADD, 16'hFFFF, 16'h0001, 1'b0, 3, 16'h0000, 1'b0, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      chk($sformatf("L%0d rst_ctrl", L),
          {cmd_ready, rsp_valid, alu_en, rsp_o, rsp_z, rsp_n, alu_mov_sel, alu_op}, 0);
      chk($sformatf("L%0d rst_data", L), {alu_a, alu_b}, 0);
      chk($sformatf("L%0d rst_rsp", L), {rsp_result, ops_done}, 0);
      rst = 1'b0;
      #1;
      chk($sformatf("L%0d ready_pre_edge", L), cmd_ready, 0);
      @(negedge clk);
      chk($sformatf("L%0d ready_post_edge", L), {cmd_ready, alu_en}, 2'b10);

      for (int i = 0; i < 7; i++)
        run_cmd(tbl[i], 16'(i + 1), $sformatf("L%0d v%0d", L, i));

      // back-to-back with cmd_valid held and rsp_ready held
      rq.delete();
      @(negedge clk);
      rsp_ready = 1'b1;
      base = acc_cnt;
      cmd_op = ALU_SUB; cmd_a = 16'hFF00; cmd_b = 16'h0002; cmd_mov = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 40 && acc_cnt != base + 1; i++) @(negedge clk);
      cmd_op = ALU_ADD; cmd_a = 16'h0003; cmd_b = 16'h0004;
      for (int i = 0; i < 40 && acc_cnt != base + 2; i++) @(negedge clk);
      cmd_valid = 1'b0;
      chk($sformatf("L%0d b2b_accepts", L), acc_cnt - base, 2);
      chk($sformatf("L%0d b2b_spacing", L), acc_last - acc_prev, L + 4);
      for (int i = 0; i < 40 && rq.size() < 2; i++) @(negedge clk);
      rsp_ready = 1'b0;
      chk($sformatf("L%0d b2b_count", L), rq.size(), 2);
      if (rq.size() >= 2) begin
        chk($sformatf("L%0d b2b_rsp0", L), rq[0], {16'hFEFE, 3'b001});
        chk($sformatf("L%0d b2b_rsp1", L), rq[1], {16'h0007, 3'b000});
      end
      chk($sformatf("L%0d b2b_ops", L), ops_done, 16'd9);

      // reset while waiting on the ALU
      @(negedge clk);
      cmd_op = ALU_ADD; cmd_a = 16'h0005; cmd_b = 16'h0006; cmd_valid = 1'b1;
      wait_ready(ok);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk($sformatf("L%0d midrst_ctrl", L), {cmd_ready, rsp_valid, alu_en, alu_op}, 0);
      chk($sformatf("L%0d midrst_data", L), {alu_a, rsp_result, ops_done}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      saw = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (rsp_valid) saw = 1'b1;
      end
      rsp_ready = 1'b0;
      chk($sformatf("L%0d midrst_no_rsp", L), saw, 0);
      v = '{ALU_ADD, 16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, 1'b0};
      run_cmd(v, 16'd1, $sformatf("L%0d post_rst", L));

      // counter wrap
      @(negedge clk);
      force u_dut.ops_done = 16'hFFFF;
      @(negedge clk);
      release u_dut.ops_done;
      v = '{ALU_ADD, 16'h0010, 16'h0020, 1'b0, 1, 16'h0030, 1'b0, 1'b0, 1'b0};
      run_cmd(v, 16'h0000, $sformatf("L%0d wrap", L));

      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 20000; t++) begin
      if (g_lane[0].fin && g_lane[1].fin) break;
      @(negedge clk);
    end
    chk("lanes_finished", {g_lane[0].fin, g_lane[1].fin}, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
